instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage directly upstream of the instruction queue. Holds the fetch PC and issues word reads to the I-cache through a read/resp handshake. Pushes {pc, next_pc, instr} into the queue and stalls while the queue is full. A flush with a redirect PC restarts fetch; a cache read still outstanding at the flush is drained and discarded.

Parameters:
RESET_PC, 32'h00000060, PC loaded on reset.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
flush  input  1  redirect request from commit/branch resolution
redirect_pc  input  32  new fetch PC, valid while flush=1
imem_read  output  1  I-cache read request
imem_address  output  32  I-cache word address; bits [1:0] always 0
imem_resp  input  1  I-cache read complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
iq_full  input  1  instruction queue full
iq_load  output  1  push strobe to instruction queue
pc_out  output  32  PC of the pushed instruction
next_pc_out  output  32  predicted next PC of the pushed instruction
instr_out  output  32  pushed instruction word

Behaviour:
- State register values: FETCH, HOLD, DISCARD. Registers: pc, req_addr, hold_instr.
- Reset: state=FETCH, pc=RESET_PC. imem_read=0 and iq_load=0 in the reset cycle.
- All data outputs are 0 whenever iq_load=0.
- FETCH: imem_read=1 and imem_address=req_addr. req_addr is loaded from pc on entry and held stable until imem_resp.
  - imem_resp & !iq_full: iq_load=1 in the same cycle (combinational), with pc_out=pc, next_pc_out=npc, instr_out=imem_rdata. Then pc<=npc and the next request starts the following cycle. Throughput is one instruction per cache response.
  - imem_resp & iq_full: hold_instr<=imem_rdata and go to HOLD.
- HOLD: imem_read=0. iq_load=!iq_full, driving hold_instr and the registered pc/npc. On push, pc<=npc and go to FETCH.
- iq_full is treated conservatively: no push while iq_full=1, even if the queue shifts in the same cycle.
- npc = pc+4 (modulo 2^32) unless the optional feature is compiled in.
- flush has the highest priority. redirect_pc[1:0] is forced to 0.
  - FETCH with no imem_resp this cycle: pc<=redirect_pc, go to DISCARD.
  - FETCH with imem_resp this cycle: iq_load=0 and the response is dropped. pc<=redirect_pc, stay in FETCH; the new request starts next cycle.
  - HOLD: hold_instr is dropped, iq_load=0. pc<=redirect_pc, go to FETCH.
  - DISCARD: pc<=redirect_pc (the latest flush wins), stay in DISCARD.
- DISCARD: imem_read=1 with the old req_addr, because the cache cannot abort a request. On imem_resp the data is dropped, iq_load=0, and the state goes to FETCH.
- Reset mid-request: state returns to FETCH. The cache is reset by the same rst, so no drain is needed.
- iq_load is never asserted while flush=1.

Optional Feature:
BTFN_PREDICT_EN.
- Defined: npc comes from a predecode of the instruction being pushed.
  - JAL: pc + J-imm.
  - BRANCH with negative B-imm: pc + B-imm.
  - Everything else, including JALR: pc+4.
- Undefined: npc = pc+4 always.
- In both cases next_pc_out equals the PC actually fetched next.

Decomposition:
- Opcodes op_jal and op_br, plus the rv32i_word type, come from rv32i_types.
- Add a fetch_state_t enum (FETCH, HOLD, DISCARD) to rv32i_types.
- Sub-module fetch_predecode: combinational pc/instr -> npc computation. It holds the immediate decode under BTFN_PREDICT_EN.

Test Plan:
- Reset, then the cache responds after 2 cycles with 32'h00000013: imem_address=0x60. iq_load pulses with pc_out=0x60, next_pc_out=0x64. The next request goes to 0x64.
- iq_full=1 when the response at 0x64 arrives: state HOLD, imem_read=0. Drop iq_full after 3 cycles: one push with pc_out=0x64, then a request to 0x68.
- flush with redirect_pc=0x200 while a request to 0x68 is pending (no resp):
  - imem_address stays 0x68 until resp.
  - That response is not pushed.
  - The next request is 0x200.
- flush (redirect 0x300) in the same cycle as imem_resp: iq_load=0, and the next request is 0x300.
- flush in DISCARD twice (0x400, then 0x500): after the drain, the request goes to 0x500.
- BTFN_PREDICT_EN, beq with offset -8 at 0x100: next_pc_out=0xF8 and the next fetch is 0xF8. With the macro off: 0x104.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types and opcodes, plus the fetch-stage state encoding.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    localparam logic [6:0] op_jal = 7'b1101111;
    localparam logic [6:0] op_br  = 7'b1100011;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Next-PC predecode for the fetch stage.
// Macro BTFN_PREDICT_EN: JAL and backward branches predicted taken; otherwise pc+4.
module fetch_predecode
    import rv32i_types::*;
(
    input  rv32i_word pc_i,
    input  rv32i_word instr_i,
    output rv32i_word npc_o
);

`ifdef BTFN_PREDICT_EN
    rv32i_word j_imm_s;
    rv32i_word b_imm_s;
    rv32i_word target_s;

    assign j_imm_s = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign b_imm_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};

    // Backward-taken / forward-not-taken target selection
    always_comb begin
        target_s = pc_i + 32'd4;
        case (instr_i[6:0])
            op_jal: target_s = pc_i + j_imm_s;
            op_br: begin
                if (instr_i[31]) begin
                    target_s = pc_i + b_imm_s;
                end else begin
                    target_s = pc_i + 32'd4;
                end
            end
            default: target_s = pc_i + 32'd4;
        endcase
    end

    // Fetch addresses are word aligned; a halfword offset cannot be followed.
    assign npc_o = target_s & 32'hFFFF_FFFC;
`else
    logic unused_instr_s;

    assign unused_instr_s = ^instr_i;
    assign npc_o          = pc_i + 32'd4;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues I-cache word reads and pushes {pc, next_pc, instr} to the
// instruction queue. Optional macro BTFN_PREDICT_EN enables static next-PC prediction.
module instr_fetch
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        iq_full,
    output logic        iq_load,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] instr_out
);

    fetch_state_t state_q, state_d;
    rv32i_word    pc_q, pc_d;
    rv32i_word    req_addr_q, req_addr_d;
    rv32i_word    hold_instr_q, hold_instr_d;

    logic         read_s;
    logic         load_s;
    rv32i_word    redirect_s;
    rv32i_word    pd_instr_s;
    rv32i_word    npc_s;

    assign redirect_s = redirect_pc & 32'hFFFF_FFFC;
    assign pd_instr_s = (state_q == HOLD) ? hold_instr_q : imem_rdata;

    fetch_predecode u_predecode (
        .pc_i    (pc_q),
        .instr_i (pd_instr_s),
        .npc_o   (npc_s)
    );

    // Next-state, PC update and handshake strobes
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        read_s       = 1'b0;
        load_s       = 1'b0;
        case (state_q)
            FETCH: begin
                read_s = 1'b1;
                if (flush) begin
                    pc_d    = redirect_s;
                    state_d = imem_resp ? FETCH : DISCARD;
                end else if (imem_resp) begin
                    if (!iq_full) begin
                        load_s = 1'b1;
                        pc_d   = npc_s;
                    end else begin
                        hold_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_d    = redirect_s;
                    state_d = FETCH;
                end else if (!iq_full) begin
                    load_s  = 1'b1;
                    pc_d    = npc_s;
                    state_d = FETCH;
                end else begin
                    state_d = HOLD;
                end
            end
            DISCARD: begin
                // The cache cannot abort, so the stale request stays on the bus.
                read_s = 1'b1;
                if (flush) begin
                    pc_d    = redirect_s;
                    state_d = imem_resp ? FETCH : DISCARD;
                end else if (imem_resp) begin
                    state_d = FETCH;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (state_d == FETCH) begin
            req_addr_d = pc_d;
        end else begin
            req_addr_d = req_addr_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            hold_instr_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign imem_read    = read_s & ~rst;
    assign iq_load      = load_s & ~rst;
    assign imem_address = req_addr_q;
    assign pc_out       = iq_load ? pc_q       : 32'h0000_0000;
    assign next_pc_out  = iq_load ? npc_s      : 32'h0000_0000;
    assign instr_out    = iq_load ? pd_instr_s : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios, then randomized traffic
// against a request-level reference model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        iq_full;
    logic        iq_load;
    logic [31:0] pc_out;
    logic [31:0] next_pc_out;
    logic [31:0] instr_out;

    int n_cmp = 0;
    int n_bad = 0;
    int wait_cnt = 2;
    logic rst_v = 1'b1;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .iq_full      (iq_full),
        .iq_load      (iq_load),
        .pc_out       (pc_out),
        .next_pc_out  (next_pc_out),
        .instr_out    (instr_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expired(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait budget expired at %0t", nm, $time);
    endtask

    // Instruction memory contents: fixed words for the directed part, hashed elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h0000_0100) return 32'hFE00_0CE3;
        if (a < 32'h0000_0200) return 32'h0000_0013;
        h = (a * 32'h9E37_79B1) ^ (a >> 7);
        case (h[2:0])
            3'd0:    return {h[31:7], 7'b1101111};
            3'd1:    return {h[31:7], 7'b1100011};
            default: return {h[31:7], 7'b0010011};
        endcase
    endfunction

    // Reference next-PC from the instruction's immediate value
    function automatic logic [31:0] m_npc(input logic [31:0] pc, input logic [31:0] ins);
        longint off;
        logic [20:0] j;
        logic [12:0] b;
        off = 4;
`ifdef BTFN_PREDICT_EN
        j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (ins[6:0] == 7'b1101111) begin
            off = longint'(j);
            if (ins[31]) off = off - 64'sd2097152;
        end else if (ins[6:0] == 7'b1100011 && ins[31]) begin
            off = longint'(b) - 64'sd8192;
        end
`else
        j = 21'd0;
        b = 13'd0;
`endif
        return 32'(longint'(pc) + off) & 32'hFFFF_FFFC;
    endfunction

    // One cycle of stimulus: cache response, flush (0 none, 1 always, 2 only with resp), queue full
    task automatic step(input int fmode, input logic [31:0] rpc, input logic full,
                        input int lat_lo, input int lat_hi);
        @(negedge clk);
        if (imem_read && !rst_v) begin
            if (wait_cnt == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(imem_address);
                wait_cnt   = $urandom_range(lat_hi, lat_lo);
            end else begin
                imem_resp  = 1'b0;
                imem_rdata = $urandom;
                wait_cnt--;
            end
        end else begin
            imem_resp  = 1'b0;
            imem_rdata = $urandom;
        end
        rst         = rst_v;
        flush       = (fmode == 1) || (fmode == 2 && imem_resp);
        redirect_pc = rpc;
        iq_full     = full;
        #2;
    endtask

    // Compare process: request-level reference model checked every cycle
    initial begin
        logic [31:0] m_pc, m_hinstr, m_saddr, e_instr;
        logic        m_held, m_stale, e_load;
        m_pc = 32'h60; m_hinstr = 32'h0; m_saddr = 32'h0; m_held = 1'b0; m_stale = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                chk("rst_read", {31'b0, imem_read}, 32'd0);
                chk("rst_load", {31'b0, iq_load}, 32'd0);
                m_pc = 32'h60; m_held = 1'b0; m_stale = 1'b0;
            end else begin
                chk("m_read", {31'b0, imem_read}, {31'b0, !m_held});
                if (!m_held) chk("m_addr", imem_address, m_stale ? m_saddr : m_pc);
                e_instr = m_held ? m_hinstr : imem_rdata;
                e_load  = !flush && !iq_full && (m_held || (imem_resp && !m_stale));
                chk("m_load", {31'b0, iq_load}, {31'b0, e_load});
                chk("m_pc_out", pc_out, e_load ? m_pc : 32'h0);
                chk("m_next_pc", next_pc_out, e_load ? m_npc(m_pc, e_instr) : 32'h0);
                chk("m_instr", instr_out, e_load ? e_instr : 32'h0);
                if (flush) begin
                    if (m_held) begin
                        m_held = 1'b0;
                    end else if (m_stale) begin
                        if (imem_resp) m_stale = 1'b0;
                    end else if (!imem_resp) begin
                        m_stale = 1'b1;
                        m_saddr = m_pc;
                    end
                    m_pc = redirect_pc & 32'hFFFF_FFFC;
                end else if (m_held) begin
                    if (!iq_full) begin
                        m_held = 1'b0;
                        m_pc   = m_npc(m_pc, m_hinstr);
                    end
                end else if (imem_resp) begin
                    if (m_stale) m_stale = 1'b0;
                    else if (iq_full) begin
                        m_held   = 1'b1;
                        m_hinstr = imem_rdata;
                    end else m_pc = m_npc(m_pc, imem_rdata);
                end
            end
        end
    end

    // Directed scenarios with literal expectations, then random traffic
    initial begin
        logic        got;
        logic [31:0] exp_br;
        rst = 1'b1; flush = 1'b0; redirect_pc = 32'h0; imem_resp = 1'b0;
        imem_rdata = 32'h0; iq_full = 1'b0;

        repeat (3) step(0, 32'h0, 1'b0, 2, 2);
        rst_v = 1'b0;
        step(0, 32'h0, 1'b0, 2, 2);
        chk("first_read", {31'b0, imem_read}, 32'd1);
        chk("first_addr", imem_address, 32'h60);

        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(0, 32'h0, 1'b0, 2, 2);
            got = iq_load;
        end
        if (!got) expired("push_0x60");
        chk("push60_pc", pc_out, 32'h60);
        chk("push60_npc", next_pc_out, 32'h64);
        chk("push60_instr", instr_out, 32'h13);
        step(0, 32'h0, 1'b0, 2, 2);
        chk("req_0x64", imem_address, 32'h64);

        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(0, 32'h0, 1'b1, 2, 2);
            got = imem_resp;
        end
        if (!got) expired("resp_0x64");
        chk("full_no_load", {31'b0, iq_load}, 32'd0);
        repeat (3) begin
            step(0, 32'h0, 1'b1, 2, 2);
            chk("hold_read", {31'b0, imem_read}, 32'd0);
            chk("hold_load", {31'b0, iq_load}, 32'd0);
        end
        step(0, 32'h0, 1'b0, 2, 2);
        chk("hold_push", {31'b0, iq_load}, 32'd1);
        chk("hold_pc", pc_out, 32'h64);
        chk("hold_npc", next_pc_out, 32'h68);
        step(0, 32'h0, 1'b0, 2, 2);
        chk("req_0x68", imem_address, 32'h68);

        step(1, 32'h200, 1'b0, 2, 2);
        chk("flush_no_resp", {31'b0, imem_resp}, 32'd0);
        chk("flush_addr", imem_address, 32'h68);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(0, 32'h0, 1'b0, 2, 2);
            chk("drain_addr", imem_address, 32'h68);
            got = imem_resp;
        end
        if (!got) expired("drain_0x68");
        chk("drain_drop", {31'b0, iq_load}, 32'd0);
        step(0, 32'h0, 1'b0, 2, 2);
        chk("req_0x200", imem_address, 32'h200);

        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(2, 32'h300, 1'b0, 3, 3);
            got = imem_resp;
        end
        if (!got) expired("resp_0x200");
        chk("flush_resp_drop", {31'b0, iq_load}, 32'd0);
        step(0, 32'h0, 1'b0, 2, 2);
        chk("req_0x300", imem_address, 32'h300);

        step(1, 32'h400, 1'b0, 2, 2);
        chk("f400_no_resp", {31'b0, imem_resp}, 32'd0);
        step(1, 32'h500, 1'b0, 2, 2);
        chk("f500_no_resp", {31'b0, imem_resp}, 32'd0);
        chk("discard_addr", imem_address, 32'h300);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(0, 32'h0, 1'b0, 2, 2);
            got = imem_resp;
        end
        if (!got) expired("drain_0x300");
        chk("discard_drop", {31'b0, iq_load}, 32'd0);
        step(0, 32'h0, 1'b0, 2, 2);
        chk("req_0x500", imem_address, 32'h500);

`ifdef BTFN_PREDICT_EN
        exp_br = 32'hF8;
`else
        exp_br = 32'h104;
`endif
        step(1, 32'h100, 1'b0, 2, 2);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step(0, 32'h0, 1'b0, 2, 2);
            got = iq_load;
        end
        if (!got) expired("push_0x100");
        chk("br_pc", pc_out, 32'h100);
        chk("br_instr", instr_out, 32'hFE00_0CE3);
        chk("br_npc", next_pc_out, exp_br);
        step(0, 32'h0, 1'b0, 2, 2);
        chk("br_next_req", imem_address, exp_br);

        for (int i = 0; i < 4000; i++) begin
            rst_v = ($urandom_range(0, 599) == 0);
            step(($urandom_range(0, 19) == 0) ? 1 : 0, $urandom,
                 ($urandom_range(0, 9) < 3), 0, 3);
        end
        rst_v = 1'b0;
        step(0, 32'h0, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
